lcd_fill_scheduler: RTL
=======================

Name: lcd_fill_scheduler

Overview:
- Sits between several rectangle-fill requesters and one ili934x_driver instance; the driver is a single shared resource.
- Sequences display bring-up, then serves fill requests round-robin. Per granted request: program the window, start the stream, feed a solid 16-bit RGB565 colour until the rectangle is full.
- Gives the requesters exclusive, ordered access to the panel without each one having to understand the driver handshake.

Parameters:
- NREQ, 2, number of requesters (1..4).
- X_RES, 240, panel width in pixels.
- Y_RES, 320, panel height in pixels.
- CW, 17, pixel-counter width; must satisfy 2**CW > X_RES*Y_RES.

Ports:
- clk  in  1  system clock (125 MHz).
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a pending fill.
- req_x0, req_y0, req_x1, req_y1  in  NREQ*16 each  packed inclusive rectangle corners; requester i uses bits [16*i +: 16].
- req_color  in  NREQ*16  packed RGB565 fill colour.
- req_ack  out  NREQ  one-cycle pulse; request i was latched.
- done_stb  out  1  one-cycle pulse; the current fill has completed or been rejected.
- done_id  out  2  requester index for done_stb.
- done_err  out  1  qualifies done_stb; 1 means the rectangle was rejected.
- ready  out  1  high in IDLE after init has finished.
- drv_init_start  out  1  held high until drv_init_done is seen.
- drv_init_done  in  1  from the driver.
- drv_busy  in  1  from the driver.
- drv_win_set_stb  out  1  one-cycle window strobe.
- drv_win_x0, drv_win_y0, drv_win_x1, drv_win_y1  out  16 each  window coordinates, clamped.
- drv_stream_start  out  1  one-cycle pulse.
- drv_pix_data  out  16  pixel colour.
- drv_pix_valid  out  1  pixel handshake, valid side.
- drv_pix_ready  in  1  pixel handshake, ready side.

Behaviour:
- Reset: all outputs are 0; the state returns to INIT_REQ and the round-robin pointer points at requester NREQ-1, so requester 0 wins first.
- Reset is honoured in any state, including mid-stream. Every strobe and valid drops at the next edge and the panel is re-initialised.
- INIT_REQ: drive drv_init_start=1 and stay until drv_init_done=1, then drop drv_init_start and go to IDLE.
- IDLE: ready=1. If any req_valid bit is set, go to ARB.
- ARB (1 cycle):
  - Grant the first valid index after the pointer, wrapping modulo NREQ; the pointer becomes the granted index.
  - Pulse req_ack[g] and latch the coordinates and colour for g.
  - Clamp: x values to X_RES-1, y values to Y_RES-1.
  - If clamped x0>x1 or y0>y1, go to DONE with err=1.
  - Otherwise go to WIN.
- WIN (1 cycle): drv_win_set_stb=1 with the clamped coordinates. The drv_win_* outputs hold their value until the next grant.
- WIN_WAIT:
  - Ignore drv_busy in the first cycle after the strobe.
  - From the second cycle on, leave for START on the first cycle drv_busy=0.
- START (1 cycle):
  - Pulse drv_stream_start.
  - Load cnt = (x1-x0+1)*(y1-y0+1) at CW bits, full product with no truncation.
  - Go to STREAM.
- STREAM:
  - drv_pix_valid=1 and drv_pix_data=colour, held stable while ready=0.
  - Each cycle with valid&ready decrements cnt.
  - When the transfer that takes cnt from 1 to 0 occurs, deassert valid on the next edge and go to DONE.
- DONE (1 cycle): pulse done_stb with done_id=g and done_err, then go to IDLE.
- Latency:
  - A request is acked 2 cycles after req_valid is seen in IDLE (IDLE→ARB).
  - The first pix_valid comes 4 cycles after the ack, plus the busy wait.
- req_valid that changes during service is ignored until the next ARB. A requester must keep req_valid and its data stable until req_ack.
- Simultaneous requests are served strictly round-robin; no requester is served twice while another is pending.
- Full-screen boundary: 0,0..239,319 gives cnt=76800.
- Single pixel: x0=x1 and y0=y1 gives cnt=1, i.e. exactly one transfer.

Optional Feature:
- Macro LCD_FILL_PERF_EN.
- When defined, add ports perf_pix (32-bit out) and perf_stall (32-bit out).
  - perf_pix counts every valid&ready cycle.
  - perf_stall counts every cycle with valid=1 and ready=0.
  - Both are cleared only by rst and saturate at 0xFFFFFFFF.
- When undefined, neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
- Reset, driver model asserts init_done 50 cycles after init_start → drv_init_start high for exactly that span, then ready=1; no window strobe before init_done.
- Req0 rect (10,20)-(13,21), colour 0xF800, ready always 1 → one win_set_stb with 10/20/13/21, stream_start once, exactly 8 beats of 0xF800, done_stb id=0 err=0.
- Same rect with ready toggling 1-0-0-1 → still 8 beats; pix_data stable through stalls; perf_stall equals the zero-ready cycles when LCD_FILL_PERF_EN is defined.
- Req0 and Req1 valid continuously → acks alternate 0,1,0,1; done_id alternates to match.
- Req1 (300,400)-(5,5) → clamped to (239,319)-(5,5), x0>x1, done_stb err=1, no win_set_stb and no pix_valid.
- Full screen (0,0)-(239,319) then rst asserted at beat 1000 → all outputs 0 the next cycle, INIT_REQ re-entered, drv_init_start reasserted.

Source files
------------

// File: rtl/lcd_fill_scheduler.sv
// Round-robin rectangle-fill scheduler in front of a single ili934x_driver.
// Optional LCD_FILL_PERF_EN adds saturating pixel/stall counters (perf_pix, perf_stall).
module lcd_fill_scheduler #(
   parameter int NREQ  = 2,
   parameter int X_RES = 240,
   parameter int Y_RES = 320,
   parameter int CW    = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*16-1:0]   req_x0,
   input  logic [NREQ*16-1:0]   req_y0,
   input  logic [NREQ*16-1:0]   req_x1,
   input  logic [NREQ*16-1:0]   req_y1,
   input  logic [NREQ*16-1:0]   req_color,
   output logic [NREQ-1:0]      req_ack,
   output logic                 done_stb,
   output logic [1:0]           done_id,
   output logic                 done_err,
   output logic                 ready,
   output logic                 drv_init_start,
   input  logic                 drv_init_done,
   input  logic                 drv_busy,
   output logic                 drv_win_set_stb,
   output logic [15:0]          drv_win_x0,
   output logic [15:0]          drv_win_y0,
   output logic [15:0]          drv_win_x1,
   output logic [15:0]          drv_win_y1,
   output logic                 drv_stream_start,
   output logic [15:0]          drv_pix_data,
   output logic                 drv_pix_valid,
   input  logic                 drv_pix_ready
`ifdef LCD_FILL_PERF_EN
   ,
   output logic [31:0]          perf_pix,
   output logic [31:0]          perf_stall
`endif
);

   typedef enum logic [2:0] {
      S_INIT_REQ,
      S_IDLE,
      S_ARB,
      S_WIN,
      S_WIN_WAIT,
      S_START,
      S_STREAM,
      S_DONE
   } state_t;

   localparam logic [15:0] XMAX = 16'(X_RES - 1);
   localparam logic [15:0] YMAX = 16'(Y_RES - 1);

   state_t          state;
   state_t          nxt;
   logic [1:0]      ptr;
   logic [1:0]      gnt;
   logic [15:0]     color;
   logic [CW-1:0]   cnt;
   logic            ww_first;

   logic [1:0]      gnt_idx;
   logic            gnt_found;
   int unsigned     idx;
   logic [NREQ-1:0] rv_rot;
   logic [NREQ-1:0] ack_nxt;
   logic [15:0]     sel_x0, sel_y0, sel_x1, sel_y1, sel_color;
   logic [15:0]     cx0, cy0, cx1, cy1;
   logic            rect_bad;
   logic [15:0]     dx, dy;
   logic            beat;

   // Search starts one past the last grant so every pending requester is served before a repeat.
   always_comb begin
      gnt_idx   = ptr;
      gnt_found = 1'b0;
      idx       = 0;
      rv_rot    = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx    = (32'(ptr) + k) % NREQ;
         rv_rot = req_valid >> idx;
         if (!gnt_found && rv_rot[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = 2'(idx);
         end
      end
      ack_nxt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         ack_nxt[i] = (state == S_ARB) && gnt_found && (32'(gnt_idx) == i);
      end
   end

   always_comb begin
      sel_x0    = 16'(req_x0    >> (16 * 32'(gnt_idx)));
      sel_y0    = 16'(req_y0    >> (16 * 32'(gnt_idx)));
      sel_x1    = 16'(req_x1    >> (16 * 32'(gnt_idx)));
      sel_y1    = 16'(req_y1    >> (16 * 32'(gnt_idx)));
      sel_color = 16'(req_color >> (16 * 32'(gnt_idx)));
      cx0       = (sel_x0 > XMAX) ? XMAX : sel_x0;
      cx1       = (sel_x1 > XMAX) ? XMAX : sel_x1;
      cy0       = (sel_y0 > YMAX) ? YMAX : sel_y0;
      cy1       = (sel_y1 > YMAX) ? YMAX : sel_y1;
      rect_bad  = (cx0 > cx1) || (cy0 > cy1);
      dx        = drv_win_x1 - drv_win_x0 + 16'd1;
      dy        = drv_win_y1 - drv_win_y0 + 16'd1;
      beat      = drv_pix_valid && drv_pix_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_INIT_REQ;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_INIT_REQ: if (drv_init_start && drv_init_done) nxt = S_IDLE;
         S_IDLE:     if (|req_valid) nxt = S_ARB;
         S_ARB: begin
            if (!gnt_found)    nxt = S_IDLE;
            else if (rect_bad) nxt = S_DONE;
            else               nxt = S_WIN;
         end
         S_WIN:      nxt = S_WIN_WAIT;
         S_WIN_WAIT: if (!ww_first && !drv_busy) nxt = S_START;
         S_START:    nxt = S_STREAM;
         S_STREAM:   if (beat && cnt == CW'(1)) nxt = S_DONE;
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_INIT_REQ;
      endcase
   end

   // Outputs are registered from the next state so each one is live for exactly its state's cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ack          <= '0;
         done_stb         <= 1'b0;
         done_id          <= '0;
         done_err         <= 1'b0;
         ready            <= 1'b0;
         drv_init_start   <= 1'b0;
         drv_win_set_stb  <= 1'b0;
         drv_win_x0       <= '0;
         drv_win_y0       <= '0;
         drv_win_x1       <= '0;
         drv_win_y1       <= '0;
         drv_stream_start <= 1'b0;
         drv_pix_data     <= '0;
         drv_pix_valid    <= 1'b0;
         ptr              <= 2'(NREQ - 1);
         gnt              <= '0;
         color            <= '0;
         cnt              <= '0;
         ww_first         <= 1'b0;
      end else begin
         req_ack          <= ack_nxt;
         drv_init_start   <= (nxt == S_INIT_REQ);
         ready            <= (nxt == S_IDLE);
         drv_win_set_stb  <= (nxt == S_WIN);
         drv_stream_start <= (nxt == S_START);
         drv_pix_valid    <= (nxt == S_STREAM);
         done_stb         <= (nxt == S_DONE);
         done_err         <= (state == S_ARB) && (nxt == S_DONE);
         done_id          <= (nxt != S_DONE) ? 2'd0 : ((state == S_ARB) ? gnt_idx : gnt);
         ww_first         <= (state == S_WIN);
         if (state == S_ARB && gnt_found) begin
            gnt        <= gnt_idx;
            ptr        <= gnt_idx;
            color      <= sel_color;
            drv_win_x0 <= cx0;
            drv_win_y0 <= cy0;
            drv_win_x1 <= cx1;
            drv_win_y1 <= cy1;
         end
         if (state == S_START) begin
            cnt          <= CW'({16'd0, dx} * {16'd0, dy});
            drv_pix_data <= color;
         end else if (state == S_STREAM && beat) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

`ifdef LCD_FILL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_pix   <= '0;
         perf_stall <= '0;
      end else begin
         if (drv_pix_valid && drv_pix_ready && perf_pix != '1)
            perf_pix <= perf_pix + 32'd1;
         if (drv_pix_valid && !drv_pix_ready && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
